// File: rtl/vga_scroll_addr_gen.sv
// Frame-buffer address generator with scroll, wipe and split display effects.
// Maps raster (h_cnt, v_cnt) to an image RAM address plus a pixel enable.
// Both outputs are registered, so they appear one cycle after the raster inputs.
module vga_scroll_addr_gen #(
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned STEP        = 1,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              pause,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_mode,
    output logic              cmd_ready,
    input  logic              valid,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_en,
    output logic [2:0]        state,
    output logic              busy,
    output logic [9:0]        count
);

    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned SW = ((XW > 10) ? XW : 10) + 1;

    typedef enum logic [2:0] {
        SCROLL_L = 3'd0,
        SCROLL_R = 3'd1,
        SCROLL_U = 3'd2,
        SCROLL_D = 3'd3,
        WIPE_L   = 3'd4,
        WIPE_D   = 3'd5,
        SPLIT    = 3'd6,
        IDLE     = 3'd7
    } mode_e;

    mode_e             state_q, state_d;
    logic [XW-1:0]     off_x_q, off_x_d;
    logic [YW-1:0]     off_y_q, off_y_d;
    logic [9:0]        count_q, count_d;
    logic              busy_q, busy_d;
    logic              ready_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en_q, en_d;

    logic              accept;
    logic [10:0]       cnt_inc;
    logic [SW-1:0]     hx, vy, sum_x, sum_y, img_x, img_y;
    logic [YW-1:0]     eff_y;
    logic              mask;

    // Mode register, scroll offsets, wipe progress and both output stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            off_x_q <= '0;
            off_y_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            addr_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            off_x_q <= off_x_d;
            off_y_q <= off_y_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= !busy_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
        end
    end

    // Next mode and effect step; an accepted command takes priority over a tick.
    always_comb begin
        state_d = state_q;
        off_x_d = off_x_q;
        off_y_d = off_y_q;
        count_d = count_q;
        accept  = cmd_valid && ready_q;
        cnt_inc = 11'(count_q) + 11'(STEP);

        if (accept) begin
            state_d = mode_e'(cmd_mode);
            count_d = '0;
            if (cmd_mode == 3'(IDLE)) begin
                off_x_d = '0;
                off_y_d = '0;
            end
        end else if (tick && !pause) begin
            case (state_q)
                SCROLL_L: off_x_d = (off_x_q >= XW'(IMG_W - STEP)) ?
                                    off_x_q - XW'(IMG_W - STEP) : off_x_q + XW'(STEP);
                SCROLL_R: off_x_d = (off_x_q < XW'(STEP)) ?
                                    off_x_q + XW'(IMG_W - STEP) : off_x_q - XW'(STEP);
                SCROLL_U,
                SPLIT:    off_y_d = (off_y_q >= YW'(IMG_H - STEP)) ?
                                    off_y_q - YW'(IMG_H - STEP) : off_y_q + YW'(STEP);
                SCROLL_D: off_y_d = (off_y_q < YW'(STEP)) ?
                                    off_y_q + YW'(IMG_H - STEP) : off_y_q - YW'(STEP);
                WIPE_L: begin
                    if (count_q == 10'(H_ACTIVE)) begin
                        count_d = '0;
                        state_d = IDLE;
                    end else if (cnt_inc >= 11'(H_ACTIVE)) begin
                        count_d = 10'(H_ACTIVE);
                    end else begin
                        count_d = cnt_inc[9:0];
                    end
                end
                WIPE_D: begin
                    if (count_q == 10'(V_ACTIVE)) begin
                        count_d = '0;
                        state_d = IDLE;
                    end else if (cnt_inc >= 11'(V_ACTIVE)) begin
                        count_d = 10'(V_ACTIVE);
                    end else begin
                        count_d = cnt_inc[9:0];
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == WIPE_L) || (state_d == WIPE_D);
    end

    // Address and mask stage: downscale, add offsets with wrap, linearise.
    always_comb begin
        hx    = SW'(h_cnt >> SCALE_SHIFT);
        vy    = SW'(v_cnt >> SCALE_SHIFT);
        eff_y = off_y_q;
        if ((state_q == SPLIT) && (h_cnt >= 10'(H_ACTIVE / 2)) && (off_y_q != '0)) begin
            eff_y = YW'(IMG_H) - off_y_q;
        end
        sum_x  = hx + SW'(off_x_q);
        sum_y  = vy + SW'(eff_y);
        img_x  = (sum_x >= SW'(IMG_W)) ? sum_x - SW'(IMG_W) : sum_x;
        img_y  = (sum_y >= SW'(IMG_H)) ? sum_y - SW'(IMG_H) : sum_y;
        addr_d = ADDR_W'(img_y) * ADDR_W'(IMG_W) + ADDR_W'(img_x);

        case (state_q)
            WIPE_L:  mask = 11'(h_cnt) < (11'(H_ACTIVE) - 11'(count_q));
            WIPE_D:  mask = v_cnt < count_q;
            default: mask = 1'b1;
        endcase
        en_d = valid && mask;
    end

    assign state      = state_q;
    assign count      = count_q;
    assign busy       = busy_q;
    assign cmd_ready  = ready_q;
    assign pixel_addr = addr_q;
    assign pixel_en   = en_q;

endmodule

// File: tb/tb_vga_scroll_addr_gen.sv
// Bench for vga_scroll_addr_gen: directed vector table, hand-written corner
// sequences, and random traffic, all checked against an arithmetic model.
module tb_vga_scroll_addr_gen;

    localparam int IMG_W    = 320;
    localparam int IMG_H    = 240;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int STEP     = 1;
    localparam int ADDR_W   = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick, pause, cmd_valid, valid;
    logic [2:0]        cmd_mode;
    logic [9:0]        h_cnt, v_cnt;
    logic              cmd_ready, pixel_en, busy;
    logic [ADDR_W-1:0] pixel_addr;
    logic [2:0]        state;
    logic [9:0]        count;

    vga_scroll_addr_gen dut (
        .clk(clk), .rst(rst), .tick(tick), .pause(pause),
        .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
        .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .pixel_addr(pixel_addr), .pixel_en(pixel_en),
        .state(state), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_state, m_offx, m_offy, m_cnt;
    int e_addr, e_en;

    typedef struct {
        bit t, p, cv;
        int cm;
        bit v;
        int h, vv;
        int ea, een, est;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_busy();
        return (m_state == 4) || (m_state == 5);
    endfunction

    task automatic model_reset();
        m_state = 7; m_offx = 0; m_offy = 0; m_cnt = 0;
        e_addr = 0; e_en = 0;
    endtask

    task automatic wipe_step(input int lim);
        if (m_cnt == lim) begin
            m_cnt = 0;
            m_state = 7;
        end else begin
            m_cnt = (m_cnt + STEP > lim) ? lim : m_cnt + STEP;
        end
    endtask

    // Apply one clock edge worth of inputs to the model
    task automatic model_edge(input bit t, input bit p, input bit cv, input int cm,
                              input bit v, input int h, input int vv);
        int ix, iy, effy;
        bit msk;
        effy = (m_state == 6 && h >= H_ACTIVE / 2) ? (IMG_H - m_offy) % IMG_H : m_offy;
        ix = ((h >> 1) + m_offx) % IMG_W;
        iy = ((vv >> 1) + effy) % IMG_H;
        e_addr = (iy * IMG_W + ix) % (1 << ADDR_W);
        if (m_state == 4)      msk = h < H_ACTIVE - m_cnt;
        else if (m_state == 5) msk = vv < m_cnt;
        else                   msk = 1'b1;
        e_en = (v && msk) ? 1 : 0;

        if (cv && !m_busy()) begin
            if (cm == 7) begin
                m_offx = 0;
                m_offy = 0;
            end
            m_state = cm;
            m_cnt = 0;
        end else if (t && !p) begin
            case (m_state)
                0:    m_offx = (m_offx + STEP) % IMG_W;
                1:    m_offx = (m_offx - STEP + IMG_W) % IMG_W;
                2, 6: m_offy = (m_offy + STEP) % IMG_H;
                3:    m_offy = (m_offy - STEP + IMG_H) % IMG_H;
                4:    wipe_step(H_ACTIVE);
                5:    wipe_step(V_ACTIVE);
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        chk("pixel_addr", int'(pixel_addr), e_addr);
        chk("pixel_en", int'(pixel_en), e_en);
        chk("state", int'(state), m_state);
        chk("count", int'(count), m_cnt);
        chk("busy", int'(busy), int'(m_busy()));
        chk("cmd_ready", int'(cmd_ready), int'(!m_busy()));
    endtask

    task automatic cycle(input bit t, input bit p, input bit cv, input int cm,
                         input bit v, input int h, input int vv);
        @(negedge clk);
        tick = t; pause = p; cmd_valid = cv; cmd_mode = 3'(cm);
        valid = v; h_cnt = 10'(h); v_cnt = 10'(vv);
        @(posedge clk);
        model_edge(t, p, cv, cm, v, h, vv);
        #1;
        check_all();
    endtask

    task automatic rand_tick(input bit cv, input int cm);
        cycle(1'b1, 1'b0, cv, cm, 1'($urandom % 2), int'($urandom % 640), int'($urandom % 480));
    endtask

    initial begin
        tbl[0] = '{t:0, p:0, cv:0, cm:0, v:1, h:10,  vv:4, ea:645, een:1, est:7};
        tbl[1] = '{t:0, p:0, cv:1, cm:0, v:0, h:0,   vv:0, ea:0,   een:0, est:0};
        tbl[2] = '{t:1, p:0, cv:0, cm:0, v:1, h:638, vv:0, ea:319, een:1, est:0};
        tbl[3] = '{t:0, p:0, cv:0, cm:0, v:1, h:638, vv:0, ea:0,   een:1, est:0};

        rst = 1'b1;
        tick = 0; pause = 0; cmd_valid = 0; cmd_mode = 0; valid = 0; h_cnt = 0; v_cnt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", int'(state), 7);
        chk("rst_addr", int'(pixel_addr), 0);
        chk("rst_en", int'(pixel_en), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        rst = 1'b0;

        // Vector table: idle mapping, SCROLL_L accept, first tick, wrap
        for (int i = 0; i < 4; i++) begin
            cycle(tbl[i].t, tbl[i].p, tbl[i].cv, tbl[i].cm, tbl[i].v, tbl[i].h, tbl[i].vv);
            chk("tbl_addr", int'(pixel_addr), tbl[i].ea);
            chk("tbl_en", int'(pixel_en), tbl[i].een);
            chk("tbl_state", int'(state), tbl[i].est);
        end

        // SCROLL_L full revolution returns to the identity mapping
        for (int i = 0; i < 319; i++) rand_tick(1'b0, 0);
        cycle(0, 0, 0, 0, 1, 10, 4);
        chk("scroll_l_320", int'(pixel_addr), 645);

        // SCROLL_R wrapping below zero
        cycle(0, 0, 1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("scroll_r_wrap", int'(pixel_addr), 319);

        // WIPE_L: busy, commands ignored, mask boundary, completion
        cycle(0, 0, 1, 4, 1, 0, 0);
        chk("wipe_l_busy", int'(busy), 1);
        chk("wipe_l_ready", int'(cmd_ready), 0);
        for (int i = 0; i < 100; i++) rand_tick(1'b1, 0);
        chk("wipe_l_state", int'(state), 4);
        chk("wipe_l_cnt100", int'(count), 100);
        cycle(0, 0, 0, 0, 1, 539, 0);
        chk("wipe_l_en_539", int'(pixel_en), 1);
        cycle(0, 0, 0, 0, 1, 540, 0);
        chk("wipe_l_en_540", int'(pixel_en), 0);
        for (int i = 0; i < 540; i++) rand_tick(1'b0, 0);
        chk("wipe_l_cnt640", int'(count), 640);
        chk("wipe_l_st640", int'(state), 4);
        rand_tick(1'b0, 0);
        chk("wipe_l_done_state", int'(state), 7);
        chk("wipe_l_done_cnt", int'(count), 0);
        chk("wipe_l_done_ready", int'(cmd_ready), 1);

        // Command and tick on the same edge: command wins
        cycle(0, 0, 1, 7, 0, 0, 0);
        cycle(1, 0, 1, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("cmd_wins_addr", int'(pixel_addr), 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("scroll_u_addr", int'(pixel_addr), 320);

        // SPLIT: left and right halves, pause freezes
        cycle(0, 0, 1, 6, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("split_left", int'(pixel_addr), 320);
        cycle(0, 0, 0, 0, 1, 320, 0);
        chk("split_right", int'(pixel_addr), 76640);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        chk("split_pause", int'(pixel_addr), 320);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom % 2), 1'($urandom % 4 == 0), 1'($urandom % 16 == 0),
                  int'($urandom % 8), 1'($urandom % 2),
                  int'($urandom % 640), int'($urandom % 480));
        end

        // Drain any wipe left by random traffic, bounded
        for (int i = 0; i < 2000 && m_busy(); i++) rand_tick(1'b0, 0);
        if (m_busy()) chk("drain_timeout", 1, 0);

        // WIPE_D aborted by async reset between edges
        cycle(0, 0, 1, 5, 0, 0, 0);
        for (int i = 0; i < 50; i++) rand_tick(1'b0, 0);
        chk("wipe_d_cnt50", int'(count), 50);
        chk("wipe_d_state", int'(state), 5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_state", int'(state), 7);
        chk("arst_count", int'(count), 0);
        chk("arst_en", int'(pixel_en), 0);
        chk("arst_addr", int'(pixel_addr), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, 0, 1, 10, 4);
        chk("post_rst_addr", int'(pixel_addr), 645);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scroll_addr_gen.md
Name: vga_scroll_addr_gen

Overview:
Parametrised successor to the frame-buffer address generator. Maps VGA raster coordinates (h_cnt, v_cnt) to a block-RAM pixel address with a registered output. Applies one of eight display effects: four continuous wrap-around scrolls, two one-shot wipes, a split scroll, and stop. Sits between vga_controller and the image ROM. It runs entirely on the pixel clock, and effect steps are gated by a one-cycle tick enable.

Parameters:
IMG_W, 320, stored image width in pixels
IMG_H, 240, stored image height in pixels
SCALE_SHIFT, 1, raster-to-image downscale (img = raster >> SCALE_SHIFT)
H_ACTIVE, 640, visible raster width
V_ACTIVE, 480, visible raster height
STEP, 1, offset/count increment per tick; must satisfy STEP < IMG_W, STEP < IMG_H and STEP <= V_ACTIVE
ADDR_W, 17, pixel_addr width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
tick  in  1  single-cycle step enable (e.g. one per frame)
pause  in  1  freezes offsets and wipe count while high
cmd_valid  in  1  command request
cmd_mode  in  3  0 SCROLL_L, 1 SCROLL_R, 2 SCROLL_U, 3 SCROLL_D, 4 WIPE_L, 5 WIPE_D, 6 SPLIT, 7 STOP
cmd_ready  out  1  command may be accepted
valid  in  1  raster in active area
h_cnt  in  10  raster column
v_cnt  in  10  raster row
pixel_addr  out  ADDR_W  image RAM address, 1-cycle latency
pixel_en  out  1  1 = show pixel, 0 = force black; aligned with pixel_addr
state  out  3  current mode; IDLE = 7
busy  out  1  high in WIPE_L or WIPE_D
count  out  10  wipe progress

Behaviour:
- Reset (async): state=IDLE, off_x=0, off_y=0, count=0, pixel_addr=0, pixel_en=0, cmd_ready=1, busy=0.
- cmd_ready = !busy. A command is accepted on a clk edge where cmd_valid && cmd_ready. The new state is visible the next cycle.
- On acceptance, off_x and off_y are kept for scrolls and SPLIT, and count is cleared.
- STOP: state=IDLE, off_x=off_y=count=0.
- Command and tick on the same edge: the command wins and no step occurs that edge.
- Step happens on an edge with tick && !pause && no accepted command:
  - SCROLL_L: off_x=(off_x+STEP) mod IMG_W.
  - SCROLL_R: off_x=(off_x-STEP) mod IMG_W, wrapping below 0.
  - SCROLL_U: off_y=(off_y+STEP) mod IMG_H.
  - SCROLL_D: off_y=(off_y-STEP) mod IMG_H.
  - SPLIT: off_y=(off_y+STEP) mod IMG_H.
  - WIPE_L: if count==H_ACTIVE, then count=0 and state=IDLE; else count=min(count+STEP, H_ACTIVE).
  - WIPE_D: same rule against V_ACTIVE.
  - IDLE: no change.
- Scroll and SPLIT modes run until a new command arrives. Wipes cannot be interrupted except by rst.
- Address stage (registered, 1 cycle):
  - hx = h_cnt>>SCALE_SHIFT, vy = v_cnt>>SCALE_SHIFT.
  - img_x = hx+off_x, minus IMG_W if the sum >= IMG_W. A single conditional subtract suffices because hx < IMG_W and off_x < IMG_W.
  - img_y uses the same rule with vy and the effective y offset.
  - Effective y offset: off_y in all modes except SPLIT right half (h_cnt >= H_ACTIVE/2), where it is (IMG_H-off_y) mod IMG_H.
  - pixel_addr = img_y*IMG_W + img_x.
- Mask (registered, same cycle as the address):
  - pixel_en = valid && mask.
  - WIPE_L: mask = h_cnt < H_ACTIVE-count.
  - WIPE_D: mask = v_cnt < count.
  - All other states: mask = 1.
  - When valid=0, pixel_en=0 and pixel_addr still updates.
- Reset asserted mid-wipe aborts immediately to reset values. No partial state survives.

Test Plan:
- Reset, IDLE, valid=1, h_cnt=10, v_cnt=4 -> one cycle later pixel_addr=645, pixel_en=1; cmd_ready=1, state=7.
- Accept SCROLL_L, then 1 tick; h_cnt=638, v_cnt=0 -> pixel_addr=0 (wrap). After 320 total ticks, off_x=0 and h_cnt=10, v_cnt=4 again yields 645. SCROLL_R from off_x=0 with 1 tick, h_cnt=0, v_cnt=0 -> pixel_addr=319.
- Accept WIPE_L -> busy=1, cmd_ready=0; cmd_valid held with mode 0 is ignored. After 100 ticks, count=100; h_cnt=539 gives pixel_en=1 and h_cnt=540 gives pixel_en=0. After tick 641, state=IDLE, count=0, cmd_ready=1.
- cmd_valid(SCROLL_U) and tick on the same edge -> off_y stays 0. The next tick gives off_y=1, and v_cnt=0, h_cnt=0 gives pixel_addr=320.
- SPLIT with off_y=1: h_cnt=0, v_cnt=0 -> pixel_addr=320; h_cnt=640/2=320, v_cnt=0 -> pixel_addr=239*320+160=76640. With pause=1 held for 10 ticks, off_y stays 1.
- WIPE_D started, after 50 ticks assert rst asynchronously between edges -> outputs immediately at reset values, state=7, count=0, pixel_en=0.
